cipher_frame_ctrl: RTL and testbench

//  Sequencer between the UART receiver, the block cipher core and the UART transmitter.
//  - Collects BLOCK_BYTES received bytes into one block.
//  - Starts the cipher and waits for it to finish.
//  - Sends the result back byte-by-byte through the transmitter handshake.
//  - Only one block is in flight; bytes arriving outside collection are dropped and flagged.

---
 rtl/cipher_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_cipher_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_frame_ctrl.sv
// cipher_frame_ctrl: sequencer between UART receiver, block cipher core and UART transmitter.
// Gathers BLOCK_BYTES received bytes into one block, runs the cipher once, then returns the
// result byte-by-byte over the transmitter handshake. Only one block is in flight at a time.
// Optional feature: define FRAME_TIMEOUT_EN to discard a partial block after TIMEOUT_CYCLES
// of inter-byte idle time in COLLECT.
//
// Handshakes: rx_done is a level; only its rising edge (rx_done=1, previous cycle 0) delivers
// a byte. cph_start and tx_start are single-cycle pulses; cph_done is sampled as a level while
// waiting for the cipher; tx_busy must rise after tx_start (TX_ACK) and fall again (TX_DRAIN)
// before the next byte is offered, and tx_data stays constant across that window.
module cipher_frame_ctrl #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_done,
  input  logic [7:0]                      rx_data,
  output logic                            cph_start,
  output logic [8*BLOCK_BYTES-1:0]        cph_block_in,
  input  logic                            cph_done,
  input  logic [8*BLOCK_BYTES-1:0]        cph_block_out,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  input  logic                            tx_busy,
  output logic                            busy,
  output logic                            err_overrun,
  output logic [2:0]                      dbg_state,
  output logic [$clog2(BLOCK_BYTES)-1:0]  dbg_byte_cnt
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    START_CPH = 3'd1,
    WAIT_CPH  = 3'd2,
    SEND      = 3'd3,
    TX_ACK    = 3'd4,
    TX_DRAIN  = 3'd5
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         byte_cnt;
  logic                     rx_done_q;
  logic [8*BLOCK_BYTES-1:0] result_q;
  logic                     rx_edge;
  logic                     last_lane;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;
`endif

  assign rx_edge      = rx_done & ~rx_done_q;
  assign last_lane    = (byte_cnt == CNT_W'(BLOCK_BYTES - 1));
  assign busy         = (state_q != COLLECT);
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT:   if (rx_edge && last_lane) state_d = START_CPH;
      START_CPH: state_d = WAIT_CPH;
      WAIT_CPH:  if (cph_done) state_d = SEND;
      SEND:      if (!tx_busy) state_d = TX_ACK;
      TX_ACK:    if (tx_busy) state_d = TX_DRAIN;
      TX_DRAIN:  if (!tx_busy) state_d = last_lane ? COLLECT : SEND;
      default:   state_d = COLLECT;
    endcase
  end

  // Datapath: byte lanes, result register, pulses, overrun flag and byte counter.
  // Pulses are registered, so cph_start lands the cycle after START_CPH is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_q    <= 1'b0;
      byte_cnt     <= '0;
      cph_block_in <= '0;
      result_q     <= '0;
      cph_start    <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      err_overrun  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      rx_done_q <= rx_done;
      cph_start <= 1'b0;
      tx_start  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt    <= '0;
`endif
      // Bytes outside COLLECT are dropped; state is judged before any transition.
      if (rx_edge && (state_q != COLLECT)) err_overrun <= 1'b1;
      case (state_q)
        COLLECT: begin
          if (rx_edge) begin
            cph_block_in[{byte_cnt, 3'b000} +: 8] <= rx_data;
            if (!last_lane) byte_cnt <= byte_cnt + 1'b1;
          end
`ifdef FRAME_TIMEOUT_EN
          else if (byte_cnt != '0) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) byte_cnt <= '0;
            else                                     to_cnt   <= to_cnt + 1'b1;
          end
`endif
        end
        START_CPH: cph_start <= 1'b1;
        WAIT_CPH: begin
          if (cph_done) begin
            result_q <= cph_block_out;
            byte_cnt <= '0;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= result_q[{byte_cnt, 3'b000} +: 8];
            tx_start <= 1'b1;
          end
        end
        TX_DRAIN: begin
          if (!tx_busy) byte_cnt <= last_lane ? '0 : byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// Directed bench for cipher_frame_ctrl: edge-detection vector table, then hand-written
// block sequences against a behavioural cipher (XOR with a byte mask) and transmitter.
module tb_cipher_frame_ctrl;
  localparam int BB = 16;
  localparam int W  = 8 * BB;
  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          cph_start;
  logic [W-1:0]  cph_block_in;
  logic          cph_done;
  logic [W-1:0]  cph_block_out;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          busy;
  logic          err_overrun;
  logic [2:0]    dbg_state;
  logic [3:0]    dbg_byte_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int start_cnt = 0;
  int tx_cnt = 0;
  int tx_viol = 0;
  int tx_hold = 3;
  int cph_delay = 10;
  logic [7:0] cph_mask = 8'h00;
  logic [7:0] last_tx = 8'h00;

  typedef struct {
    logic       rd;
    logic [7:0] d;
    logic [3:0] exp_cnt;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;
  vec_t vecs[10];

  cipher_frame_ctrl #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .cph_start(cph_start), .cph_block_in(cph_block_in), .cph_done(cph_done),
    .cph_block_out(cph_block_out), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .err_overrun(err_overrun),
    .dbg_state(dbg_state), .dbg_byte_cnt(dbg_byte_cnt)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural cipher: result = block XOR replicated mask, cph_delay cycles after cph_start.
  initial begin : cipher_model
    cph_done = 1'b0;
    cph_block_out = '0;
    forever begin
      @(negedge clk);
      if (cph_start && !rst) begin
        start_cnt++;
        repeat (cph_delay) @(negedge clk);
        cph_block_out = cph_block_in ^ {BB{cph_mask}};
        cph_done = 1'b1;
        @(negedge clk);
        cph_done = 1'b0;
      end
    end
  end

  // Behavioural transmitter: busy for tx_hold cycles after each tx_start.
  initial begin : tx_model
    int left;
    left = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        left = 0;
      end else if (tx_start) begin
        if (tx_busy) tx_viol++;
        tx_cnt++;
        got_q.push_back(tx_data);
        last_tx = tx_data;
        tx_busy = 1'b1;
        left = tx_hold;
      end else if (left > 0) begin
        if (tx_data !== last_tx) tx_viol++;
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
    end
  end

  // Driver: one byte, rx_done high for hold cycles then one low cycle.
  task automatic send_byte(input logic [7:0] d, input int hold, input bit expect_tx);
    @(negedge clk);
    rx_data = d;
    rx_done = 1'b1;
    if (expect_tx) exp_q.push_back(d ^ cph_mask);
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n_tx, input int max_cyc, input string name);
    int k;
    k = 0;
    while (!(tx_cnt >= n_tx && !busy) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, W'(k < max_cyc), W'(1));
  endtask

  // Scoreboard: transmitted bytes against expected queue, then clear both.
  task automatic compare_sb(input string name);
    logic [7:0] e;
    logic [7:0] g;
    check({name, "_count"}, W'(got_q.size()), W'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, "_byte"}, W'(g), W'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin : main
    int s0;
    int t0;
    int v0;
    int k;
    int n_new;

    vecs[0] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA0, 4'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hA0, 4'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hA0, 4'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hA1, 4'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 4'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hA2, 4'd3, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'hA2, 4'd3, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 4'd3, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", W'(dbg_state), W'(S_COLLECT));
    check("rst_outs", W'({cph_start, tx_start, tx_data, busy, err_overrun}), W'(0));
    check("rst_block", cph_block_in, W'(0));
    check("rst_cnt", W'(dbg_byte_cnt), W'(0));
    rst = 1'b0;

    // Edge-detection table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_done = vecs[i].rd;
      rx_data = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt", i), W'(dbg_byte_cnt), W'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_busy", i), W'(busy), W'(vecs[i].exp_busy));
      check($sformatf("vec%0d_err", i), W'(err_overrun), W'(vecs[i].exp_err));
    end
    check("vec_lanes", W'(cph_block_in[31:0]), W'(32'h00A2A1A0));

    // Full block 0x00..0x0F, long rx_done levels, echo cipher, with start latency.
    do_reset();
    tx_hold = 3; cph_mask = 8'h00; cph_delay = 10;
    s0 = start_cnt; t0 = tx_cnt; v0 = tx_viol;
    for (int i = 0; i < 15; i++) send_byte(8'(i), 652, 1'b1);
    @(negedge clk);
    rx_data = 8'h0F;
    rx_done = 1'b1;
    exp_q.push_back(8'h0F);
    @(negedge clk);
    check("lat_c1_start", W'(cph_start), W'(0));
    check("lat_c1_state", W'(dbg_state), W'(S_START));
    @(negedge clk);
    check("lat_c2_start", W'(cph_start), W'(1));
    repeat (650) @(negedge clk);
    rx_done = 1'b0;
    wait_done(t0 + 16, 2000, "t1_done");
    check("t1_starts", W'(start_cnt - s0), W'(1));
    check("t1_lane0", W'(cph_block_in[7:0]), W'(8'h00));
    check("t1_lane15", W'(cph_block_in[127:120]), W'(8'h0F));
    check("t1_busy", W'(busy), W'(0));
    check("t1_err", W'(err_overrun), W'(0));
    check("t1_txviol", W'(tx_viol - v0), W'(0));
    compare_sb("t1");

    // Single byte held 5000 cycles counts once.
    do_reset();
    @(negedge clk);
    rx_data = 8'h55;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_cnt_early", W'(dbg_byte_cnt), W'(1));
    repeat (897) @(negedge clk);
    check("t2_cnt_900", W'(dbg_byte_cnt), W'(1));
    repeat (4100) @(negedge clk);
`ifdef FRAME_TIMEOUT_EN
    check("t2_cnt_end", W'(dbg_byte_cnt), W'(0));
`else
    check("t2_cnt_end", W'(dbg_byte_cnt), W'(1));
`endif
    rx_done = 1'b0;
    check("t2_err", W'(err_overrun), W'(0));

    // Extra byte during WAIT_CPH is dropped and flagged.
    do_reset();
    tx_hold = 3; cph_mask = 8'h5A; cph_delay = 40;
    s0 = start_cnt; t0 = tx_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i * 7 + 3), 2, 1'b1);
    send_byte(8'hEE, 2, 1'b0);
    check("t3_err_set", W'(err_overrun), W'(1));
    wait_done(t0 + 16, 2000, "t3_done");
    check("t3_err_hold", W'(err_overrun), W'(1));
    check("t3_starts", W'(start_cnt - s0), W'(1));
    compare_sb("t3");

    // Slow transmitter: 200 busy cycles per byte.
    do_reset();
    tx_hold = 200; cph_mask = 8'hC3; cph_delay = 10;
    t0 = tx_cnt; v0 = tx_viol;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 - i), 2, 1'b1);
    wait_done(t0 + 16, 8000, "t5_done");
    repeat (50) @(negedge clk);
    check("t5_txcnt", W'(tx_cnt - t0), W'(16));
    check("t5_txviol", W'(tx_viol - v0), W'(0));
    compare_sb("t5");

    // Reset in SEND after three bytes transmitted.
    do_reset();
    tx_hold = 5; cph_mask = 8'h00; cph_delay = 10;
    t0 = tx_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h30), 2, 1'b1);
    k = 0;
    while (!((tx_cnt - t0) == 3 && dbg_state == S_SEND) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t4_reach_send", W'(k < 2000), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_state", W'(dbg_state), W'(S_COLLECT));
    check("t4_outs", W'({cph_start, tx_start, tx_data, busy, err_overrun}), W'(0));
    check("t4_block", cph_block_in, W'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("t4_txcnt", W'(tx_cnt - t0), W'(3));
    exp_q.delete();
    got_q.delete();

    // Partial block then long idle.
    do_reset();
    tx_hold = 3; cph_mask = 8'h0F; cph_delay = 10;
    t0 = tx_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i), 2, 1'b1);
    repeat (1000) @(negedge clk);
`ifdef FRAME_TIMEOUT_EN
    check("t6_cnt_idle", W'(dbg_byte_cnt), W'(0));
    exp_q.delete();
    n_new = 16;
`else
    check("t6_cnt_idle", W'(dbg_byte_cnt), W'(5));
    n_new = 11;
`endif
    for (int i = 0; i < n_new; i++) send_byte(8'(8'h20 + i), 2, 1'b1);
    wait_done(t0 + 16, 2000, "t6_done");
    check("t6_err", W'(err_overrun), W'(0));
    compare_sb("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
